// File: rtl/tlb_search_arbiter_pkg.sv
// Shared types for the main-TLB search arbiter: TLB entry layout, FSM states, owner encoding.
// Pure declarations; no timing or flow control of its own.
package tlb_search_arbiter_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLB_Entry;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} tlb_arb_state_t;
  typedef enum logic [1:0] {NONE, OWN_I, OWN_D, OWN_P} tlb_owner_t;

  // Bit positions of the one-hot grant / mask vectors.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;
  localparam int GNT_P = 2;

endpackage

// File: rtl/tlb_search_arbiter_prio.sv
// Combinational pick among masked requests: P > D > I, except a starved I beats D.
// Zero latency; no backpressure, the caller decides when the grant is taken.
module tlb_search_arbiter_prio
  import tlb_search_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int STREAK_W   = 3
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic                p_req,
  input  logic [STREAK_W-1:0] streak,
  output logic [2:0]          gnt
);

  logic i_starved;
  assign i_starved = i_req && (streak == STREAK_W'(MAX_CONSEC));

  always_comb begin
    gnt = '0;
    if (p_req)          gnt[GNT_P] = 1'b1;
    else if (i_starved) gnt[GNT_I] = 1'b1;
    else if (d_req)     gnt[GNT_D] = 1'b1;
    else if (i_req)     gnt[GNT_I] = 1'b1;
  end

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares the single main-TLB search port between I-miss, D-miss and TLBP; done pulses SRCH_LAT+1 cycles after grant.
// Requesters hold level requests until their done; flush cancels I/D searches, TLBP always completes.
module tlb_search_arbiter
  import tlb_search_arbiter_pkg::*;
#(
  parameter int VPN2_W     = 19,
  parameter int IDX_W      = 4,
  parameter int SRCH_LAT   = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [VPN2_W-1:0] i_vpn2,
  input  logic              d_req,
  input  logic [VPN2_W-1:0] d_vpn2,
  input  logic              p_req,
  input  logic [VPN2_W-1:0] p_vpn2,
  input  logic              flush,
  output logic              srch_valid,
  output logic [VPN2_W-1:0] srch_vpn2,
  input  logic              srch_found,
  input  logic [IDX_W-1:0]  srch_index,
  input  TLB_Entry          srch_entry,
  output logic              i_done,
  output logic              d_done,
  output logic              p_done,
  output logic              rsp_found,
  output logic [IDX_W-1:0]  rsp_index,
  output TLB_Entry          rsp_entry,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_CONSEC + 1);
  localparam int LAT_W    = 2;

  tlb_arb_state_t      state_q, state_d;
  tlb_owner_t          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [2:0]          mask_q, mask_d;
  logic [VPN2_W-1:0]   srch_vpn2_q, srch_vpn2_d;
  logic                rsp_found_q, rsp_found_d;
  logic [IDX_W-1:0]    rsp_index_q, rsp_index_d;
  TLB_Entry            rsp_entry_q, rsp_entry_d;

  logic [2:0] gnt;
  logic       cancel;
  logic       last_lookup;
  logic       resp_ok;

  tlb_search_arbiter_prio #(
    .MAX_CONSEC (MAX_CONSEC),
    .STREAK_W   (STREAK_W)
  ) u_prio (
    .i_req  (i_req && !mask_q[GNT_I]),
    .d_req  (d_req && !mask_q[GNT_D]),
    .p_req  (p_req && !mask_q[GNT_P]),
    .streak (streak_q),
    .gnt    (gnt)
  );

  // Flush only kills translations feeding the I/D buffers; TLBP result is architectural.
  assign cancel      = flush && (owner_q == OWN_I || owner_q == OWN_D);
  assign last_lookup = (lat_q == LAT_W'(SRCH_LAT - 1));
  assign resp_ok     = (state_q == RESP) && !cancel;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    mask_d      = '0;
    srch_vpn2_d = srch_vpn2_q;
    rsp_found_d = rsp_found_q;
    rsp_index_d = rsp_index_q;
    rsp_entry_d = rsp_entry_q;
    streak_d    = i_req ? streak_q : '0;

    case (state_q)
      IDLE: begin
        lat_d = '0;
        if (!flush && (|gnt)) begin
          state_d = LOOKUP;
          if (gnt[GNT_P]) begin
            owner_d     = OWN_P;
            srch_vpn2_d = p_vpn2;
          end else if (gnt[GNT_D]) begin
            owner_d     = OWN_D;
            srch_vpn2_d = d_vpn2;
            if (i_req && streak_q != STREAK_W'(MAX_CONSEC)) streak_d = streak_q + STREAK_W'(1);
          end else begin
            owner_d     = OWN_I;
            srch_vpn2_d = i_vpn2;
            streak_d    = '0;
          end
        end
      end
      LOOKUP: begin
        if (cancel) begin
          state_d = IDLE;
          owner_d = NONE;
          lat_d   = '0;
        end else if (last_lookup) begin
          state_d     = RESP;
          lat_d       = '0;
          rsp_found_d = srch_found;
          rsp_index_d = srch_index;
          rsp_entry_d = srch_entry;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = NONE;
        if (!cancel) begin
          mask_d[GNT_I] = (owner_q == OWN_I);
          mask_d[GNT_D] = (owner_q == OWN_D);
          mask_d[GNT_P] = (owner_q == OWN_P);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      streak_q    <= '0;
      lat_q       <= '0;
      mask_q      <= '0;
      srch_vpn2_q <= '0;
      rsp_found_q <= 1'b0;
      rsp_index_q <= '0;
      rsp_entry_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      lat_q       <= lat_d;
      mask_q      <= mask_d;
      srch_vpn2_q <= srch_vpn2_d;
      rsp_found_q <= rsp_found_d;
      rsp_index_q <= rsp_index_d;
      rsp_entry_q <= rsp_entry_d;
    end
  end

  assign srch_valid = (state_q == LOOKUP);
  assign srch_vpn2  = srch_vpn2_q;
  assign i_done     = resp_ok && (owner_q == OWN_I);
  assign d_done     = resp_ok && (owner_q == OWN_D);
  assign p_done     = resp_ok && (owner_q == OWN_P);
  assign rsp_found  = rsp_found_q;
  assign rsp_index  = rsp_index_q;
  assign rsp_entry  = rsp_entry_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter: a SRCH_LAT=1 instance driven from a vector table plus a
// starvation sequence, and a SRCH_LAT=3 instance for the reset-during-lookup case.
module tb_tlb_search_arbiter;
  import tlb_search_arbiter_pkg::*;

  localparam logic [18:0] I_VPN = 19'h00400;
  localparam logic [18:0] D_VPN = 19'h12345;
  localparam logic [18:0] P_VPN = 19'h7ABCD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3, i_req, d_req, p_req, flush, i_req3;
  logic srch_found;
  logic [3:0] srch_index;
  TLB_Entry srch_entry;

  always_comb begin
    srch_entry      = '0;
    srch_entry.asid = 8'h5A;
    srch_entry.pfn0 = {16'hA000, srch_index};
  end

  logic sv1, id1, dd1, pd1, rf1, bz1;
  logic [18:0] vp1;
  logic [3:0] ri1;
  TLB_Entry re1;
  logic sv3, id3, dd3, pd3, rf3, bz3;
  logic [18:0] vp3;
  logic [3:0] ri3;
  TLB_Entry re3;

  tlb_search_arbiter #(.VPN2_W(19), .IDX_W(4), .SRCH_LAT(1), .MAX_CONSEC(4)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_vpn2(I_VPN), .d_req(d_req), .d_vpn2(D_VPN), .p_req(p_req), .p_vpn2(P_VPN),
    .flush(flush), .srch_valid(sv1), .srch_vpn2(vp1),
    .srch_found(srch_found), .srch_index(srch_index), .srch_entry(srch_entry),
    .i_done(id1), .d_done(dd1), .p_done(pd1),
    .rsp_found(rf1), .rsp_index(ri1), .rsp_entry(re1), .busy(bz1)
  );

  tlb_search_arbiter #(.VPN2_W(19), .IDX_W(4), .SRCH_LAT(3), .MAX_CONSEC(4)) dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req3), .i_vpn2(I_VPN), .d_req(1'b0), .d_vpn2(D_VPN), .p_req(1'b0), .p_vpn2(P_VPN),
    .flush(1'b0), .srch_valid(sv3), .srch_vpn2(vp3),
    .srch_found(srch_found), .srch_index(srch_index), .srch_entry(srch_entry),
    .i_done(id3), .d_done(dd3), .p_done(pd3),
    .rsp_found(rf3), .rsp_index(ri3), .rsp_entry(re3), .busy(bz3)
  );

  typedef struct {
    logic        sel3, rst, ir, dr, pr, fl, fnd;
    logic [3:0]  idx;
    logic        e_sv;
    logic [18:0] e_vpn;
    logic        e_id, e_dd, e_pd, e_rf;
    logic [3:0]  e_ri;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t v(input logic sel3, rst_i, ir, dr, pr, fl, fnd, input logic [3:0] idx,
                             input logic sv, input logic [18:0] vpn, input logic id, dd, pd, rf,
                             input logic [3:0] ri, input logic bz);
    vec_t t;
    t.sel3 = sel3; t.rst = rst_i; t.ir = ir; t.dr = dr; t.pr = pr; t.fl = fl; t.fnd = fnd; t.idx = idx;
    t.e_sv = sv; t.e_vpn = vpn; t.e_id = id; t.e_dd = dd; t.e_pd = pd; t.e_rf = rf; t.e_ri = ri;
    t.e_busy = bz;
    return t;
  endfunction

  task automatic run_row(input int n);
    vec_t t;
    logic sv, id, dd, pd, rf, bz;
    logic [18:0] vp;
    logic [3:0] ri;
    logic [19:0] pf, epf;
    t = tbl[n];
    if (t.sel3) begin
      rst3 = t.rst; i_req3 = t.ir;
    end else begin
      rst = t.rst; i_req = t.ir; d_req = t.dr; p_req = t.pr; flush = t.fl;
    end
    srch_found = t.fnd;
    srch_index = t.idx;
    @(negedge clk);
    if (t.sel3) begin
      sv = sv3; vp = vp3; id = id3; dd = dd3; pd = pd3; rf = rf3; ri = ri3; bz = bz3; pf = re3.pfn0;
    end else begin
      sv = sv1; vp = vp1; id = id1; dd = dd1; pd = pd1; rf = rf1; ri = ri1; bz = bz1; pf = re1.pfn0;
    end
    // Entry is all-zero until the first capture; every capture in the table has found or index nonzero.
    epf = (t.e_rf || t.e_ri != 4'h0) ? {16'hA000, t.e_ri} : 20'h0;
    checks++;
    if ({sv, vp, id, dd, pd, rf, ri, bz, pf} !== {t.e_sv, t.e_vpn, t.e_id, t.e_dd, t.e_pd, t.e_rf, t.e_ri, t.e_busy, epf}) begin
      errors++;
      $display("FAIL vec%0d: got sv=%b vpn=%h done(i,d,p)=%b%b%b rf=%b ri=%h busy=%b pfn0=%h; want sv=%b vpn=%h done=%b%b%b rf=%b ri=%h busy=%b pfn0=%h",
               n, sv, vp, id, dd, pd, rf, ri, bz, pf,
               t.e_sv, t.e_vpn, t.e_id, t.e_dd, t.e_pd, t.e_rf, t.e_ri, t.e_busy, epf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    string exp_s;
    byte   got[$];

    rst = 1'b1; rst3 = 1'b1;
    i_req = 1'b0; d_req = 1'b0; p_req = 1'b0; flush = 1'b0; i_req3 = 1'b0;
    srch_found = 1'b0; srch_index = 4'h0;
    @(posedge clk); #1;
    rst3 = 1'b0;

    //                sel rst ir dr pr fl fnd idx    sv vpn    id dd pd rf ri    busy
    // reset, single I miss, mask after done
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 19'h0, 0, 0, 0, 0, 4'h0, 0)); // 0
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 19'h0, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 4'h5, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, I_VPN, 1, 0, 0, 1, 4'h5, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'h5, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'h5, 0)); // 5
    // all three at once: p_done t2, d_done t5, i_done t8
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'h5, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 4'h3, 1, P_VPN, 0, 0, 0, 1, 4'h5, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 4'h0, 0, P_VPN, 0, 0, 1, 0, 4'h3, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 4'h0, 0, P_VPN, 0, 0, 0, 0, 4'h3, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 1, 4'h9, 1, D_VPN, 0, 0, 0, 0, 4'h3, 1)); // 10
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 4'h0, 0, D_VPN, 0, 1, 0, 1, 4'h9, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 4'h0, 0, D_VPN, 0, 0, 0, 1, 4'h9, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 4'h2, 1, I_VPN, 0, 0, 0, 1, 4'h9, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, I_VPN, 1, 0, 0, 1, 4'h2, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'h2, 0)); // 15
    // flush in LOOKUP of a D search, then D re-served
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 0, 4'hE, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 4'h7, 1, D_VPN, 0, 0, 0, 0, 4'hE, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, D_VPN, 0, 0, 0, 0, 4'hE, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 4'h0, 0, D_VPN, 0, 0, 0, 0, 4'hE, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 4'h7, 1, D_VPN, 0, 0, 0, 0, 4'hE, 1)); // 20
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 4'h0, 0, D_VPN, 0, 1, 0, 1, 4'h7, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, D_VPN, 0, 0, 0, 1, 4'h7, 0));
    // TLBP survives flush; flush in IDLE blocks the grant for that cycle
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 4'h0, 0, D_VPN, 0, 0, 0, 1, 4'h7, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 4'h1, 1, P_VPN, 0, 0, 0, 1, 4'h7, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 4'h0, 0, P_VPN, 0, 0, 1, 0, 4'h1, 1)); // 25
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 0, 4'h0, 0, P_VPN, 0, 0, 0, 0, 4'h1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, P_VPN, 0, 0, 0, 0, 4'h1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 4'h6, 1, I_VPN, 0, 0, 0, 0, 4'h1, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, I_VPN, 1, 0, 0, 1, 4'h6, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'h6, 0)); // 30
    // SRCH_LAT=3: reset in 2nd LOOKUP cycle, then a clean 4-cycle I search
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 0, 19'h0, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 4'h0, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 19'h0, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 0, 19'h0, 0, 0, 0, 0, 4'h0, 0)); // 35
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 1, 4'hB, 1, I_VPN, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 4'h0, 0, I_VPN, 1, 0, 0, 1, 4'hB, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, I_VPN, 0, 0, 0, 1, 4'hB, 0)); // 40

    for (int n = 0; n <= 15; n++) run_row(n);

    // Starvation: all requests held. P and D alternate; after 4 D grants with I waiting, I wins over D.
    // The second round shows the streak was cleared by the I grant.
    exp_s = "PDPDPDPDPIPDPDPDPDPI";
    i_req = 1'b1; d_req = 1'b1; p_req = 1'b1; flush = 1'b0;
    srch_found = 1'b0; srch_index = 4'hE;
    for (int c = 0; c < 100 && got.size() < 20; c++) begin
      @(negedge clk);
      if (pd1)      got.push_back(8'h50);
      else if (dd1) got.push_back(8'h44);
      else if (id1) got.push_back(8'h49);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++;
        $display("FAIL starve_done%0d: no done pulse within cycle budget, want %s", k, exp_s.substr(k, k));
      end else if (got[k] != exp_s[k]) begin
        errors++;
        $display("FAIL starve_done%0d: got %c, want %c", k, got[k], exp_s[k]);
      end
    end
    i_req = 1'b0; d_req = 1'b0; p_req = 1'b0;
    @(posedge clk); #1;

    for (int n = 16; n < tbl.size(); n++) run_row(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
